// File: rtl/bcd2int_if.sv
// Handshake bundle for the BCD-to-binary converter: input word channel and result channel.
interface bcd2int_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] int_out;
  logic        err;

  modport master (
    output in_valid, bcd, out_ready,
    input  in_ready, out_valid, int_out, err
  );

  modport slave (
    input  in_valid, bcd, out_ready,
    output in_ready, out_valid, int_out, err
  );
endinterface

// File: rtl/bcd2int.sv
// Sequential 4-digit packed-BCD to 14-bit binary converter, one multiply-by-10-and-add per cycle.
module bcd2int (
  input  logic      clk,
  input  logic      rst_n,
  bcd2int_if.slave  bus
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned ACC_W = 17;
  localparam int unsigned OUT_W = 14;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [BCD_W-1:0]   shadow_q,    shadow_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic               err_acc_q,   err_acc_d;
  logic [OUT_W-1:0]   int_out_q,   int_out_d;
  logic               err_q,       err_d;
  logic               out_valid_q, out_valid_d;
  logic [DIG_W-1:0]   digit;

  // Reset only takes effect on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      acc_q       <= '0;
      idx_q       <= IDX_W'(3);
      err_acc_q   <= 1'b0;
      int_out_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      err_acc_q   <= err_acc_d;
      int_out_q   <= int_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    err_acc_d   = err_acc_q;
    int_out_d   = int_out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    unique case (idx_q)
      2'd3:    digit = shadow_q[15:12];
      2'd2:    digit = shadow_q[11:8];
      2'd1:    digit = shadow_q[7:4];
      default: digit = shadow_q[3:0];
    endcase

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          shadow_d  = bus.bcd;
          acc_d     = '0;
          err_acc_d = 1'b0;
          idx_d     = IDX_W'(3);
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        // 17-bit accumulator: even all-0xF input cannot wrap before the error is flagged.
        acc_d     = acc_q * ACC_W'(10) + ACC_W'(digit);
        err_acc_d = err_acc_q | (digit > DIG_W'(9));
        idx_d     = idx_q - IDX_W'(1);
        if (idx_q == IDX_W'(0)) begin
          int_out_d   = err_acc_d ? '0 : acc_d[OUT_W-1:0];
          err_d       = err_acc_d;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // in_ready is a state decode gated by reset so it reads low while reset is held.
  assign bus.in_ready  = (state_q == ST_IDLE) && rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.int_out   = int_out_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2int.sv
// Randomized self-checking bench for bcd2int against a digit-weight arithmetic reference model.
module tb_bcd2int;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  bcd2int_if bif ();

  bcd2int u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: value = sum of digit * 10^position; any nibble above 9 gives 0 with err.
  function automatic void model(input logic [15:0] w, output int val, output int e);
    int d [4];
    d[0] = int'(w[3:0]);
    d[1] = int'(w[7:4]);
    d[2] = int'(w[11:8]);
    d[3] = int'(w[15:12]);
    e = 0;
    for (int i = 0; i < 4; i++) if (d[i] > 9) e = 1;
    val = e ? 0 : d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
  endfunction

  function automatic logic [15:0] rand_word(input bit decimal_only);
    logic [15:0] w;
    for (int i = 0; i < 4; i++)
      w[i*4 +: 4] = 4'(decimal_only ? $urandom_range(0, 9) : $urandom_range(0, 15));
    return w;
  endfunction

  // Full conversion with out_ready high; checks accept, latency, result and one-cycle out_valid.
  task automatic do_conv(input logic [15:0] w, input string tag);
    int ev, ee, lat;
    model(w, ev, ee);
    bif.out_ready = 1'b1;
    check_eq({tag, "_in_ready"}, int'(bif.in_ready), 1);
    bif.bcd      = w;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    bif.bcd      = ~w;
    lat = 0;
    while (!bif.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 4);
    check_eq({tag, "_int_out"}, int'(bif.int_out), ev);
    check_eq({tag, "_err"}, int'(bif.err), ee);
    step();
    check_eq({tag, "_ov_width"}, int'(bif.out_valid), 0);
  endtask

  initial begin
    int ev, ee, last_cyc, waitc;
    logic [15:0] words [6];
    logic [15:0] fixed [5];

    bif.in_valid  = 1'b0;
    bif.bcd       = 16'h0;
    bif.out_ready = 1'b1;
    rst_n         = 1'b0;
    step();
    step();
    check_eq("rst_out_valid", int'(bif.out_valid), 0);
    check_eq("rst_int_out", int'(bif.int_out), 0);
    check_eq("rst_err", int'(bif.err), 0);
    check_eq("rst_in_ready", int'(bif.in_ready), 0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", int'(bif.in_ready), 1);

    do_conv(16'h1234, "basic");
    fixed[0] = 16'h0000; fixed[1] = 16'h9999; fixed[2] = 16'h0009;
    fixed[3] = 16'h1000; fixed[4] = 16'h12A4;
    for (int i = 0; i < 5; i++) do_conv(fixed[i], $sformatf("bound%0d", i));
    do_conv(16'h0042, "err_clear");

    for (int i = 0; i < 30; i++) do_conv(rand_word(i % 2 == 0), $sformatf("rand%0d", i));

    // Backpressure: result must hold and inputs must be ignored.
    bif.out_ready = 1'b0;
    bif.bcd       = 16'h0505;
    bif.in_valid  = 1'b1;
    step();
    bif.in_valid = 1'b0;
    waitc = 0;
    while (!bif.out_valid && waitc < 20) begin
      step();
      waitc++;
    end
    check_eq("bp_latency", waitc, 4);
    for (int i = 0; i < 10; i++) begin
      bif.bcd      = 16'h7777;
      bif.in_valid = 1'(i % 2);
      step();
      check_eq($sformatf("bp_ov%0d", i), int'(bif.out_valid), 1);
      check_eq($sformatf("bp_int%0d", i), int'(bif.int_out), 505);
      check_eq($sformatf("bp_rdy%0d", i), int'(bif.in_ready), 0);
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    step();
    check_eq("bp_release_ov", int'(bif.out_valid), 0);
    check_eq("bp_release_rdy", int'(bif.in_ready), 1);
    check_eq("bp_hold_int", int'(bif.int_out), 505);

    // Back-to-back with in_valid and out_ready tied high; bcd scrambled after each accept.
    for (int i = 0; i < 6; i++) words[i] = rand_word(i != 3);
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      bif.bcd = words[k];
      waitc = 0;
      while (!bif.in_ready && waitc < 20) begin
        step();
        waitc++;
      end
      check_eq($sformatf("b2b_rdy%0d", k), int'(bif.in_ready), 1);
      step();
      bif.bcd = ~words[k];
      waitc = 0;
      while (!bif.out_valid && waitc < 20) begin
        step();
        waitc++;
      end
      model(words[k], ev, ee);
      check_eq($sformatf("b2b_int%0d", k), int'(bif.int_out), ev);
      check_eq($sformatf("b2b_err%0d", k), int'(bif.err), ee);
      if (k > 0) check_eq($sformatf("b2b_gap%0d", k), cyc - last_cyc, 6);
      last_cyc = cyc;
    end
    bif.in_valid = 1'b0;
    step();
    step();

    // Reset landing on the second CONV edge discards the conversion.
    bif.bcd      = 16'h8888;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", int'(bif.in_ready), 0);
    step();
    rst_n = 1'b1;
    waitc = 0;
    for (int i = 0; i < 8; i++) begin
      if (bif.out_valid) waitc++;
      step();
    end
    check_eq("midrst_no_ov", waitc, 0);
    check_eq("midrst_int_out", int'(bif.int_out), 0);
    do_conv(16'h0001, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
